// File: rtl/hilo_mul_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply controller: operand width default,
// operation encodings, FSM state encodings and a signed-op helper.
package hilo_mul_ctrl_pkg;

  localparam int unsigned WidthDefault = 32;

  typedef enum logic [2:0] {
    OpNop   = 3'b000,
    OpMult  = 3'b001,
    OpMultu = 3'b010,
    OpMadd  = 3'b011,
    OpMsub  = 3'b100,
    OpMthi  = 3'b101,
    OpMtlo  = 3'b110,
    OpRsvd  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StFix  = 2'd2,
    StAcc  = 2'd3
  } state_e;

  // MULT, MADD and MSUB treat operands as two's complement.
  function automatic logic op_is_signed(input op_e op);
    return (op == OpMult) || (op == OpMadd) || (op == OpMsub);
  endfunction

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply controller.
//   start/op/a/b : request, valid while start=1 (held by the requester while stalled)
//   read_hilo    : pipeline is executing mfhi/mflo this cycle
//   busy/done    : sequence in progress / one-cycle completion pulse
//   stall        : busy & (start | read_hilo)
//   hi/lo        : architectural HI and LO registers
interface hilo_mul_ctrl_if import hilo_mul_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = WidthDefault
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             read_hilo;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, read_hilo,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, read_hilo,
    output busy, done, stall, hi, lo
  );

endinterface

// File: rtl/shift_add_mul32.sv
// Iterative radix-2 shift-add unsigned multiplier datapath.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture mcand_i/mplr_i and clear the product
//   step_i       : perform one shift-add iteration
//   product_o    : accumulated 2*WIDTH-bit product
module shift_add_mul32 import hilo_mul_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplr_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [2*WIDTH-1:0] prod_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
    end else if (load_i) begin
      mcand_q <= {{WIDTH{1'b0}}, mcand_i};
      mplr_q  <= mplr_i;
      prod_q  <= '0;
    end else if (step_i) begin
      if (mplr_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/hilo_mul_ctrl.sv
// HI/LO multiply/accumulate controller (MULT, MULTU, MADD, MSUB, MTHI, MTLO).
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : slave side of hilo_mul_ctrl_if (request in, busy/done/stall/hi/lo out)
// Sequence: accept -> WIDTH shift-add edges -> sign fix -> accumulate into HI/LO.
module hilo_mul_ctrl import hilo_mul_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic           clk_i,
  input  logic           rst_i,
  hilo_mul_ctrl_if.slave bus
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  op_e              op_q;
  logic             neg_q;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  op_e              op_in;
  logic             in_signed;
  logic             accept_mul;
  logic             accept_mov;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    mul_product;
  logic [PW-1:0]    hilo_add;
  logic [PW-1:0]    hilo_sub;

  always_comb begin
    op_in      = op_e'(bus.op);
    in_signed  = op_is_signed(op_in);
    accept_mul = (state_q == StIdle) && bus.start &&
                 ((op_in == OpMult) || (op_in == OpMultu) ||
                  (op_in == OpMadd) || (op_in == OpMsub));
    accept_mov = (state_q == StIdle) && bus.start &&
                 ((op_in == OpMthi) || (op_in == OpMtlo));
    // Signed ops multiply magnitudes; the sign is reapplied in StFix.
    mag_a = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // Full-width add/sub so carry/borrow crosses from LO into HI.
    hilo_add = {hi_q, lo_q} + prod_q;
    hilo_sub = {hi_q, lo_q} - prod_q;
  end

  shift_add_mul32 #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept_mul),
    .step_i   (state_q == StMul),
    .mcand_i  (mag_a),
    .mplr_i   (mag_b),
    .product_o(mul_product)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNop;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept_mul) begin
            op_q    <= op_in;
            neg_q   <= in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt_q   <= '0;
            state_q <= StMul;
            busy_q  <= 1'b1;
          end else if (accept_mov) begin
            if (op_in == OpMthi) begin
              hi_q <= bus.a;
            end else begin
              lo_q <= bus.a;
            end
            done_q <= 1'b1;
          end
        end
        StMul: begin
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          prod_q  <= neg_q ? -mul_product : mul_product;
          state_q <= StAcc;
        end
        StAcc: begin
          if (op_q == OpMadd) begin
            {hi_q, lo_q} <= hilo_add;
          end else if (op_q == OpMsub) begin
            {hi_q, lo_q} <= hilo_sub;
          end else begin
            {hi_q, lo_q} <= prod_q;
          end
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.read_hilo);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
